// File: rtl/fu_wb_arbiter.sv
// fu_wb_arbiter: per-channel result FIFOs drained by one round-robin writeback port.
// Define FU_WB_ARB_BYPASS_EN to forward a result in its arrival cycle when every FIFO is empty.
package fu_wb_arbiter_pkg;
   typedef struct packed {
      logic [63:0] cause;
      logic [63:0] tval;
      logic        valid;
   } exception_t;
endpackage

module fu_wb_arbiter
   import fu_wb_arbiter_pkg::*;
#(
   parameter int unsigned NR_FU         = 4,
   parameter int unsigned DEPTH         = 2,
   parameter int unsigned DATA_W        = 64,
   parameter int unsigned TRANS_ID_BITS = 3
) (
   input  logic                                clk_i,
   input  logic                                rst_ni,
   input  logic                                flush_i,
   input  logic [NR_FU-1:0]                    fu_valid_i,
   output logic [NR_FU-1:0]                    fu_ready_o,
   input  logic [NR_FU-1:0][DATA_W-1:0]        fu_result_i,
   input  logic [NR_FU-1:0][TRANS_ID_BITS-1:0] fu_trans_id_i,
   input  exception_t [NR_FU-1:0]              fu_exception_i,
   output logic                                wb_valid_o,
   input  logic                                wb_ready_i,
   output logic [DATA_W-1:0]                   wb_result_o,
   output logic [TRANS_ID_BITS-1:0]            wb_trans_id_o,
   output exception_t                          wb_exception_o,
   output logic [$clog2(NR_FU)-1:0]            wb_fu_idx_o
);

   localparam int unsigned IDX_W = $clog2(NR_FU);
   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

   typedef struct packed {
      logic [DATA_W-1:0]        result;
      logic [TRANS_ID_BITS-1:0] trans_id;
      exception_t               exception;
   } entry_t;

   entry_t           mem_q    [NR_FU][DEPTH];
   logic [PTR_W-1:0] wr_ptr_q [NR_FU];
   logic [PTR_W-1:0] wr_ptr_d [NR_FU];
   logic [PTR_W-1:0] rd_ptr_q [NR_FU];
   logic [PTR_W-1:0] rd_ptr_d [NR_FU];
   logic [CNT_W-1:0] cnt_q    [NR_FU];
   logic [CNT_W-1:0] cnt_d    [NR_FU];
   logic [IDX_W-1:0] rr_q, rr_d;

   logic [NR_FU-1:0] not_empty, req, push, pop;
   logic             bypass, found, wb_valid, hs;
   logic [IDX_W-1:0] grant;
   int unsigned      idx;
   entry_t           grant_entry;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   always_comb begin
      for (int i = 0; i < NR_FU; i++) begin
         not_empty[i]  = (cnt_q[i] != '0);
         fu_ready_o[i] = (cnt_q[i] != CNT_W'(DEPTH));
      end
   end

`ifdef FU_WB_ARB_BYPASS_EN
   // Direct forwarding only while nothing is buffered, so FIFO order is never overtaken.
   assign bypass = ~|not_empty & ~flush_i & rst_ni;
   assign req    = bypass ? fu_valid_i : not_empty;
`else
   assign bypass = 1'b0;
   assign req    = not_empty;
`endif

   // NOTE: every combinational output gets a default before any branch, so no latch is inferred.
   always_comb begin
      found = 1'b0;
      grant = '0;
      idx   = 0;
      for (int off = 0; off < NR_FU; off++) begin
         idx = (int'(rr_q) + off) % NR_FU;
         if (!found && req[IDX_W'(idx)]) begin
            found = 1'b1;
            grant = IDX_W'(idx);
         end
      end
   end

   always_comb begin
      grant_entry = mem_q[grant][rd_ptr_q[grant]];
`ifdef FU_WB_ARB_BYPASS_EN
      if (bypass) begin
         grant_entry.result    = fu_result_i[grant];
         grant_entry.trans_id  = fu_trans_id_i[grant];
         grant_entry.exception = fu_exception_i[grant];
      end
`endif
   end

   assign wb_valid = found & ~flush_i;
   assign hs       = wb_valid & wb_ready_i;

   always_comb begin
      wb_valid_o     = wb_valid;
      wb_result_o    = '0;
      wb_trans_id_o  = '0;
      wb_exception_o = '0;
      wb_fu_idx_o    = '0;
      if (wb_valid) begin
         wb_result_o    = grant_entry.result;
         wb_trans_id_o  = grant_entry.trans_id;
         wb_exception_o = grant_entry.exception;
         wb_fu_idx_o    = grant;
      end
   end

   always_comb begin
      push = fu_valid_i & fu_ready_o & {NR_FU{~flush_i}};
      pop  = '0;
      for (int i = 0; i < NR_FU; i++) begin
         pop[i] = hs & ~bypass & (grant == IDX_W'(i));
      end
      // A forwarded result already left through the writeback port.
      if (bypass && hs) push[grant] = 1'b0;
   end

   always_comb begin
      rr_d = rr_q;
      if (hs) rr_d = (grant == IDX_W'(NR_FU - 1)) ? '0 : grant + 1'b1;
      for (int i = 0; i < NR_FU; i++) begin
         wr_ptr_d[i] = wr_ptr_q[i];
         rd_ptr_d[i] = rd_ptr_q[i];
         cnt_d[i]    = cnt_q[i];
         if (flush_i) begin
            wr_ptr_d[i] = '0;
            rd_ptr_d[i] = '0;
            cnt_d[i]    = '0;
         end else begin
            if (push[i]) wr_ptr_d[i] = ptr_inc(wr_ptr_q[i]);
            if (pop[i])  rd_ptr_d[i] = ptr_inc(rd_ptr_q[i]);
            case ({push[i], pop[i]})
               2'b10:   cnt_d[i] = cnt_q[i] + 1'b1;
               2'b01:   cnt_d[i] = cnt_q[i] - 1'b1;
               default: cnt_d[i] = cnt_q[i];
            endcase
         end
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rr_q <= '0;
         for (int i = 0; i < NR_FU; i++) begin
            wr_ptr_q[i] <= '0;
            rd_ptr_q[i] <= '0;
            cnt_q[i]    <= '0;
         end
      end else begin
         rr_q <= rr_d;
         for (int i = 0; i < NR_FU; i++) begin
            wr_ptr_q[i] <= wr_ptr_d[i];
            rd_ptr_q[i] <= rd_ptr_d[i];
            cnt_q[i]    <= cnt_d[i];
         end
      end
   end

   // NOTE: storage is deliberately not reset; occupancy alone decides which entries are live.
   always_ff @(posedge clk_i) begin
      for (int i = 0; i < NR_FU; i++) begin
         if (push[i]) begin
            mem_q[i][wr_ptr_q[i]] <= '{result:    fu_result_i[i],
                                       trans_id:  fu_trans_id_i[i],
                                       exception: fu_exception_i[i]};
         end
      end
   end

endmodule

// File: tb/tb_fu_wb_arbiter.sv
// Directed bench for fu_wb_arbiter (default build): scoreboard of buffered results
// plus a round-robin pointer model predicts every writeback beat.
module tb_fu_wb_arbiter;
   import fu_wb_arbiter_pkg::*;

   logic                  clk = 1'b0;
   logic                  rst_n;
   logic                  flush;
   logic [3:0]            fu_valid;
   logic [3:0]            fu_ready;
   logic [3:0][63:0]      fu_result;
   logic [3:0][2:0]       fu_trans_id;
   exception_t [3:0]      fu_exc;
   logic                  wb_valid;
   logic                  wb_ready;
   logic [63:0]           wb_result;
   logic [2:0]            wb_trans_id;
   exception_t            wb_exc;
   logic [1:0]            wb_fu_idx;

   fu_wb_arbiter #(.NR_FU(4), .DEPTH(2), .DATA_W(64), .TRANS_ID_BITS(3)) dut (
      .clk_i          (clk),
      .rst_ni         (rst_n),
      .flush_i        (flush),
      .fu_valid_i     (fu_valid),
      .fu_ready_o     (fu_ready),
      .fu_result_i    (fu_result),
      .fu_trans_id_i  (fu_trans_id),
      .fu_exception_i (fu_exc),
      .wb_valid_o     (wb_valid),
      .wb_ready_i     (wb_ready),
      .wb_result_o    (wb_result),
      .wb_trans_id_o  (wb_trans_id),
      .wb_exception_o (wb_exc),
      .wb_fu_idx_o    (wb_fu_idx)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [1:0]  ch;
      logic [63:0] res;
      logic [2:0]  id;
      exception_t  exc;
   } item_t;

   item_t mq[$];
   int    rr_m;
   int    n_cmp;
   int    n_mis;

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic next_cycle();
      @(negedge clk);
      fu_valid = '0;
   endtask

   // Drive one channel this cycle; acc says whether the block must take it.
   task automatic push(input int ch, input logic [63:0] d, input logic [2:0] id, input bit acc);
      item_t it;
      it.ch        = 2'(ch);
      it.res       = d;
      it.id        = id;
      it.exc.cause = {61'd0, id};
      it.exc.tval  = ~d;
      it.exc.valid = d[0];
      fu_valid[ch]    = 1'b1;
      fu_result[ch]   = d;
      fu_trans_id[ch] = id;
      fu_exc[ch]      = it.exc;
      if (acc) mq.push_back(it);
   endtask

   // Compare the writeback port with the model; retire the beat if it handshakes at the next edge.
   task automatic observe(input string tag);
      int pos;
      pos = -1;
      for (int off = 0; off < 4; off++) begin
         for (int k = 0; k < mq.size(); k++) begin
            if (pos < 0 && int'(mq[k].ch) == (rr_m + off) % 4) pos = k;
         end
      end
      if (pos < 0) begin
         check({tag, "/valid"}, 256'(wb_valid), 256'(0));
         check({tag, "/idle_data"}, 256'({wb_result, wb_trans_id, wb_fu_idx}), 256'(0));
         check({tag, "/idle_exc"}, 256'(wb_exc), 256'(0));
      end else begin
         check({tag, "/valid"}, 256'(wb_valid), 256'(1));
         check({tag, "/idx"}, 256'(wb_fu_idx), 256'(mq[pos].ch));
         check({tag, "/result"}, 256'(wb_result), 256'(mq[pos].res));
         check({tag, "/id"}, 256'(wb_trans_id), 256'(mq[pos].id));
         check({tag, "/exc"}, 256'(wb_exc), 256'(mq[pos].exc));
         if (wb_ready) begin
            rr_m = (int'(mq[pos].ch) + 1) % 4;
            mq.delete(pos);
         end
      end
   endtask

   initial begin
      n_cmp       = 0;
      n_mis       = 0;
      rr_m        = 0;
      rst_n       = 1'b0;
      flush       = 1'b0;
      fu_valid    = '0;
      fu_result   = '0;
      fu_trans_id = '0;
      fu_exc      = '0;
      wb_ready    = 1'b0;

      // Reset state
      repeat (2) @(negedge clk);
      check("rst/ready", 256'(fu_ready), 256'(4'hF));
      observe("rst");
      rst_n = 1'b1;

      // Single push on ch2: one-cycle latency, no same-cycle path
      next_cycle(); wb_ready = 1'b1; observe("a_idle");
      push(2, 64'hDEAD, 3'd5, 1'b1);
      #1 check("a/no_comb_path", 256'(wb_valid), 256'(0));
      next_cycle(); observe("a_deliver");
      push(3, 64'h3333, 3'd1, 1'b1);
      next_cycle(); observe("a_ch3");
      next_cycle(); observe("a_empty");

      // All four channels at once, rr=0: grants 0,1,2,3 then idle
      push(0, 64'hA0, 3'd0, 1'b1);
      push(1, 64'hA1, 3'd1, 1'b1);
      push(2, 64'hA2, 3'd2, 1'b1);
      push(3, 64'hA3, 3'd3, 1'b1);
      for (int i = 0; i < 5; i++) begin
         next_cycle(); observe("b_rr");
      end

      // Three pushes to ch1 with the port stalled: third is refused, output holds
      wb_ready = 1'b0; observe("c_idle");
      push(1, 64'hC1A, 3'd4, 1'b1);
      next_cycle(); check("c/ready1", 256'(fu_ready), 256'(4'hF)); observe("c_hold1");
      push(1, 64'hC1B, 3'd6, 1'b1);
      next_cycle(); check("c/ready2", 256'(fu_ready), 256'(4'b1101)); observe("c_hold2");
      push(1, 64'hC1C, 3'd7, 1'b0);
      next_cycle(); check("c/ready3", 256'(fu_ready), 256'(4'b1101)); observe("c_hold3");
      next_cycle(); wb_ready = 1'b1; observe("c_drain1");
      next_cycle(); observe("c_drain2");
      next_cycle(); observe("c_empty");

      // Occupancy 2,1,0,2 then flush; a ch2 push during flush is dropped
      wb_ready = 1'b0;
      push(0, 64'hD0A, 3'd0, 1'b1);
      push(1, 64'hD1A, 3'd1, 1'b1);
      push(3, 64'hD3A, 3'd3, 1'b1);
      next_cycle(); observe("d_fill");
      push(0, 64'hD0B, 3'd2, 1'b1);
      push(3, 64'hD3B, 3'd5, 1'b1);
      next_cycle(); check("d/ready_full", 256'(fu_ready), 256'(4'b0110)); observe("d_pre_flush");
      flush = 1'b1;
      push(2, 64'hD2, 3'd2, 1'b0);
      #1 check("d/flush_same_cycle", 256'(wb_valid), 256'(0));
      mq.delete();
      next_cycle(); flush = 1'b0;
      check("d/ready_after_flush", 256'(fu_ready), 256'(4'hF));
      wb_ready = 1'b1; observe("d_after_flush");
      // rr pointer survives the flush (rr=2 -> ch3 before ch0)
      push(0, 64'hE00, 3'd1, 1'b1);
      push(3, 64'hE03, 3'd2, 1'b1);
      for (int i = 0; i < 3; i++) begin
         next_cycle(); observe("d_rr_kept");
      end

      // Full ch0 pop+push refuses the push; ch3 pop+push at occupancy 1 keeps order
      wb_ready = 1'b0; observe("e_idle");
      push(0, 64'hF0A, 3'd1, 1'b1);
      push(3, 64'hF3A, 3'd2, 1'b1);
      next_cycle(); observe("e_fill");
      push(0, 64'hF0B, 3'd3, 1'b1);
      next_cycle(); wb_ready = 1'b1;
      check("e/ready_ch0_full", 256'(fu_ready), 256'(4'b1110)); observe("e_pop_ch3");
      push(3, 64'hF3B, 3'd4, 1'b1);
      next_cycle(); check("e/ready_ch3_occ1", 256'(fu_ready), 256'(4'b1110)); observe("e_pop_ch0");
      push(0, 64'hF0C, 3'd5, 1'b0);
      next_cycle(); check("e/ready_after", 256'(fu_ready), 256'(4'hF)); observe("e_ch3_second");
      next_cycle(); observe("e_ch0_second");
      next_cycle(); observe("e_empty");

      // Asynchronous reset in the middle of a pending transfer
      wb_ready = 1'b0;
      push(1, 64'h1111, 3'd6, 1'b1);
      next_cycle(); observe("f_pending");
      @(posedge clk); #3 rst_n = 1'b0;
      #1 check("f/valid_in_reset", 256'(wb_valid), 256'(0));
      check("f/ready_in_reset", 256'(fu_ready), 256'(4'hF));
      mq.delete();
      rr_m = 0;
      next_cycle(); observe("f_in_reset");
      rst_n = 1'b1;
      next_cycle(); wb_ready = 1'b1; observe("f_released");
      push(0, 64'h2220, 3'd0, 1'b1);
      push(3, 64'h2223, 3'd3, 1'b1);
      for (int i = 0; i < 3; i++) begin
         next_cycle(); observe("f_rr_zero");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule

// File: doc/fu_wb_arbiter.md
FU_WB_ARBITER -- requirements
Module: fu_wb_arbiter

Interface
REQ-001 The block SHALL have parameter NR_FU, default 4, giving the number of functional-unit result channels (legal range 2..8).
REQ-002 The block SHALL have parameter DEPTH, default 2, giving the per-channel result FIFO entries (power of two, 1..8).
REQ-003 The block SHALL have parameter DATA_W, default 64, giving the result width.
REQ-004 The block SHALL have port clk_i, input, 1 bit: the single clock.
REQ-005 The block SHALL have port rst_ni, input, 1 bit: reset, asynchronous and active-low.
REQ-006 The block SHALL have port flush_i, input, 1 bit: discards all buffered results.
REQ-007 The block SHALL have port fu_valid_i, input, NR_FU bits: per-channel result valid.
REQ-008 The block SHALL have port fu_ready_o, output, NR_FU bits: per-channel FIFO not full.
REQ-009 The block SHALL have port fu_result_i, input, NR_FU x DATA_W bits: per-channel result.
REQ-010 The block SHALL have port fu_trans_id_i, input, NR_FU x TRANS_ID_BITS: per-channel scoreboard ID.
REQ-011 The block SHALL have port fu_exception_i, input, NR_FU x exception_t: per-channel exception.
REQ-012 The block SHALL have port wb_valid_o, output, 1 bit: writeback valid.
REQ-013 The block SHALL have port wb_ready_i, input, 1 bit: scoreboard accepts writeback.
REQ-014 The block SHALL have port wb_result_o, output, DATA_W bits: granted result.
REQ-015 The block SHALL have port wb_trans_id_o, output, TRANS_ID_BITS bits: granted ID.
REQ-016 The block SHALL have port wb_exception_o, output, exception_t: granted exception.
REQ-017 The block SHALL have port wb_fu_idx_o, output, $clog2(NR_FU) bits: granted channel index.

Function
REQ-018 Channel i SHALL push {result, trans_id, exception} into FIFO i on a cycle with fu_valid_i[i] & fu_ready_o[i] & !flush_i.
REQ-019 fu_ready_o[i] SHALL equal "FIFO i not full" and SHALL have no combinational path from wb_ready_i or fu_valid_i.
REQ-020 The arbiter SHALL grant round-robin among channels whose FIFO is non-empty, searching from the rr pointer upward and wrapping from NR_FU-1 to 0.
REQ-021 On handshake (wb_valid_o & wb_ready_i), the granted FIFO SHALL pop and the rr pointer SHALL load granted index+1, mod NR_FU.
REQ-022 Without a handshake, grant and rr pointer SHALL hold; wb_* outputs SHALL stay stable while wb_valid_o=1 and wb_ready_i=0.
REQ-023 A simultaneous push and pop on one FIFO SHALL leave its occupancy unchanged and preserve FIFO order.
REQ-024 A full FIFO SHALL refuse pushes even in a pop cycle (ready is registered-state based).
REQ-025 Write/read pointers SHALL wrap modulo DEPTH; occupancy counter SHALL be $clog2(DEPTH)+1 bits.
REQ-026 flush_i SHALL force wb_valid_o=0 in the same cycle and SHALL empty every FIFO at the next edge; the rr pointer SHALL be kept.
REQ-027 A push coincident with flush_i SHALL be dropped.
REQ-028 When no FIFO is non-empty, wb_valid_o SHALL be 0 and wb_result_o, wb_trans_id_o, wb_exception_o, wb_fu_idx_o SHALL be 0.
REQ-029 Without bypass, latency from push to wb_valid_o SHALL be exactly 1 cycle when uncontended.

Reset
REQ-030 On rst_ni=0, all FIFOs SHALL become empty and the rr pointer 0, asynchronously.
REQ-031 During and after reset, fu_ready_o SHALL be all ones, and wb_valid_o and all wb_* data outputs SHALL be 0.

Configuration
REQ-032 When the macro FU_WB_ARB_BYPASS_EN is defined, an input that is valid on a cycle when all FIFOs are empty and flush_i=0 SHALL drive wb_* in the same cycle (latency 0). It SHALL be arbitrated round-robin among the valid inputs. It SHALL be pushed only if wb_ready_i=0.
REQ-033 When FU_WB_ARB_BYPASS_EN is undefined, there SHALL be no input-to-output combinational path, and REQ-029 latency SHALL apply.

Verification
REQ-034 Reset, then push ch2 result 0xDEAD, id 5, wb_ready_i=1 -> next cycle wb_valid_o=1, wb_result_o=0xDEAD, wb_trans_id_o=5, wb_fu_idx_o=2; 0 cycles with bypass.
REQ-035 Fill all 4 FIFOs with 1 entry each, rr=0, wb_ready_i=1 -> grants 0,1,2,3 on consecutive cycles, then wb_valid_o=0.
REQ-036 Push 3 entries to ch1 (DEPTH=2) with wb_ready_i=0 -> fu_ready_o[1]=0 after 2 pushes, 3rd not accepted, wb outputs stable on entry 1.
REQ-037 With FIFOs holding 2,1,0,2 entries, assert flush_i for one cycle -> wb_valid_o=0 that cycle, all fu_ready_o=1 and wb_valid_o=0 afterward.
REQ-038 With ch0 full, pop plus push in same cycle -> ch0 accepts nothing and occupancy drops to 1; ch3 push+pop at occupancy 1 -> stays 1, order preserved.
REQ-039 Assert rst_ni=0 mid-transfer with wb_valid_o=1 -> wb_valid_o=0 immediately, occupancy 0 and rr=0 on release.
